ring_sweep_ctrl: RTL
====================

// Module: ring_sweep_ctrl
// PURPOSE
//  Sequencer for the tapped ring oscillator and its worker. On request it steps clksel through
//  ring taps tap_min..tap_max. For each tap it flushes the ring, lets it settle, then counts rising
//  edges of a divided oscillator output over a fixed window of clk cycles. Each count goes out on a
//  valid/ready result port. Sits in the top level beside the VGA sync generator and drives the
//  clock-select and ring-flush inputs of the oscillator path.
// PARAMETERS
//  GATE_CYCLES   4096  clk cycles per measurement window
//  FLUSH_CYCLES  8     clk cycles ring_flush is held high after each tap change
//  SETTLE_CYCLES 16    clk cycles between flush release and start of window
//  CNT_W         16    edge-counter / result width
// PORTS
//  clk           in   1      system clock, all logic on rising edge
//  reset         in   1      synchronous, active-high
//  start         in   1      begin sweep; sampled only in IDLE
//  abort         in   1      cancel sweep; return to IDLE next cycle
//  tap_min       in   4      first tap (values <2 are treated as 2)
//  tap_max       in   4      last tap
//  osc_in        in   1      divided ring output (asynchronous to clk)
//  clksel        out  4      clock/tap select for oscillator mux
//  ring_flush    out  1      high = ring held disabled (ANDed into ring enable at top)
//  busy          out  1      high whenever state != IDLE
//  result_valid  out  1      result_tap/result_count valid
//  result_ready  in   1      consumer accepts result
//  result_tap    out  4      tap the result belongs to
//  result_count  out  CNT_W  rising edges of osc_in seen in window (saturating)
//  sweep_done    out  1      one-cycle pulse after last result is accepted
// BEHAVIOUR
//  Reset: state=IDLE, clksel=0, ring_flush=1, busy=0, result_valid=0, result_tap=0,
//   result_count=0, sweep_done=0, sync/edge regs=0.
//  Sync: osc_in -> 2-flop synchroniser -> edge reg; rise = s2 & ~s3. Runs in every state.
//  Effective bounds: lo = max(tap_min,2); hi = max(tap_max,lo). Both latched on start.
//  FSM (cycle counter ctr reloads on every state entry):
//   IDLE    clksel=0, ring_flush=1. start & !abort -> FLUSH with tap=lo.
//           start is ignored in every other state.
//   FLUSH   clksel=tap, ring_flush=1, FLUSH_CYCLES cycles -> SETTLE.
//   SETTLE  ring_flush=0, SETTLE_CYCLES cycles -> MEASURE with count cleared to 0.
//   MEASURE exactly GATE_CYCLES cycles; count += rise, held at 2^CNT_W-1 (no wrap).
//           Last cycle's edge is included. Then -> REPORT.
//   REPORT  result_valid=1, result_tap=tap, result_count=count. Outputs held stable while
//           !result_ready; ring keeps running (ring_flush=0).
//           On valid&ready: if tap==hi -> IDLE with sweep_done=1 for that one cycle,
//           else tap+1 -> FLUSH. result_valid drops the cycle after acceptance.
//  Latency: start at cycle 0 -> clksel=lo from cycle 1. First result_valid at cycle
//   1+FLUSH_CYCLES+SETTLE_CYCLES+GATE_CYCLES.
//  abort: any state -> IDLE next cycle. result_valid dropped, no sweep_done.
//   abort has priority over start and result_ready in the same cycle.
//  reset mid-sweep: identical to reset values next cycle; latched bounds discarded.
//  tap_min/tap_max changes during a sweep have no effect. tap never exceeds hi, so no 4-bit wrap.
//  hi==lo: single measurement, then sweep_done.
//  Outputs are registered; no combinational path from inputs to outputs.
// TESTING
//  1 Reset: assert reset 2 cycles mid-MEASURE -> all outputs at reset values,
//    clksel=0, ring_flush=1, busy=0.
//  2 Single tap: tap_min=tap_max=5, osc_in square at clk/8 -> one result: tap=5,
//    count=512 (+/-1), valid at cycle 4121, sweep_done 1 cycle after ready.
//  3 Sweep with backpressure: tap 2..4, result_ready low 10 cycles per result ->
//    results for taps 2,3,4 in order; result data stable while stalled; exactly one sweep_done.
//  4 Clamp/order: tap_min=0,tap_max=1 -> single result with tap=2;
//    tap_min=9,tap_max=6 -> single result with tap=9.
//  5 Saturation: CNT_W=8, osc_in toggling every 2 clk cycles (1024 rises) -> result_count=255.
//  6 Abort: abort during second tap's SETTLE; start+abort same cycle in IDLE ->
//    IDLE next cycle, no result_valid, no sweep_done, clksel=0.

Source files
------------

// File: rtl/ring_sweep_ctrl.sv
// rtl/ring_sweep_ctrl.sv - tapped ring oscillator sweep sequencer
//
// Steps clksel through taps lo..hi. For each tap the ring is flushed, allowed
// to settle, then rising edges of the divided oscillator output are counted
// over a fixed window of clk cycles and offered on a valid/ready result port.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   start, abort        begin sweep (IDLE only) / cancel sweep (any state)
//   tap_min, tap_max    requested tap range, latched on start
//   osc_in              divided ring output, asynchronous to clk
//   clksel, ring_flush  oscillator mux select and ring disable
//   busy                high whenever a sweep is in progress
//   result_*            per-tap edge count with valid/ready handshake
//   sweep_done          one-cycle pulse after the last result is accepted
module ring_sweep_ctrl #(
    parameter int GATE_CYCLES   = 4096,
    parameter int FLUSH_CYCLES  = 8,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       tap_min,
    input  logic [3:0]       tap_max,
    input  logic             osc_in,
    output logic [3:0]       clksel,
    output logic             ring_flush,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [3:0]       result_tap,
    output logic [CNT_W-1:0] result_count,
    output logic             sweep_done
);

    localparam int MAX_FS  = (FLUSH_CYCLES > SETTLE_CYCLES) ? FLUSH_CYCLES : SETTLE_CYCLES;
    localparam int MAX_LEN = (GATE_CYCLES > MAX_FS) ? GATE_CYCLES : MAX_FS;
    localparam int CTR_W   = $clog2(MAX_LEN) + 1;

    localparam logic [CTR_W-1:0] FLUSH_LOAD  = CTR_W'(FLUSH_CYCLES - 1);
    localparam logic [CTR_W-1:0] SETTLE_LOAD = CTR_W'(SETTLE_CYCLES - 1);
    localparam logic [CTR_W-1:0] GATE_LOAD   = CTR_W'(GATE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_SETTLE,
        S_MEASURE,
        S_REPORT
    } state_t;

    state_t             state, state_nxt;
    logic [CTR_W-1:0]   ctr, ctr_load;
    logic [3:0]         tap, tap_nxt, hi_tap;
    logic [3:0]         lo_eff, hi_eff;
    logic [CNT_W-1:0]   count, count_inc;
    logic               osc_s1, osc_s2, osc_s3;
    logic               rise;

    // Synchroniser plus edge register; free-running so the first window
    // sample after SETTLE already has valid history.
    always_ff @(posedge clk) begin
        if (reset) begin
            osc_s1 <= 1'b0;
            osc_s2 <= 1'b0;
            osc_s3 <= 1'b0;
        end else begin
            osc_s1 <= osc_in;
            osc_s2 <= osc_s1;
            osc_s3 <= osc_s2;
        end
    end

    assign rise      = osc_s2 & ~osc_s3;
    assign count_inc = (rise && (count != {CNT_W{1'b1}})) ? count + CNT_W'(1) : count;
    assign lo_eff    = (tap_min < 4'd2) ? 4'd2 : tap_min;
    assign hi_eff    = (tap_max < lo_eff) ? lo_eff : tap_max;

    always_comb begin
        state_nxt = state;
        tap_nxt   = tap;
        ctr_load  = '0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_FLUSH;
                    tap_nxt   = lo_eff;
                end
            end
            S_FLUSH:   if (ctr == '0) state_nxt = S_SETTLE;
            S_SETTLE:  if (ctr == '0) state_nxt = S_MEASURE;
            S_MEASURE: if (ctr == '0) state_nxt = S_REPORT;
            S_REPORT: begin
                if (result_ready) begin
                    if (tap == hi_tap) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_FLUSH;
                        tap_nxt   = tap + 4'd1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // abort overrides everything, including a start or an acceptance
        if (abort) begin
            state_nxt = S_IDLE;
            tap_nxt   = tap;
        end
        case (state_nxt)
            S_FLUSH:   ctr_load = FLUSH_LOAD;
            S_SETTLE:  ctr_load = SETTLE_LOAD;
            S_MEASURE: ctr_load = GATE_LOAD;
            default:   ctr_load = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            ctr          <= '0;
            tap          <= '0;
            hi_tap       <= '0;
            count        <= '0;
            clksel       <= '0;
            ring_flush   <= 1'b1;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_tap   <= '0;
            result_count <= '0;
            sweep_done   <= 1'b0;
        end else begin
            state <= state_nxt;
            tap   <= tap_nxt;

            // No state re-enters itself, so a state change marks every entry.
            if (state_nxt != state) begin
                ctr <= ctr_load;
            end else if (ctr != '0) begin
                ctr <= ctr - CTR_W'(1);
            end

            if (state == S_IDLE && state_nxt == S_FLUSH) begin
                hi_tap <= hi_eff;
            end

            if (state != S_MEASURE && state_nxt == S_MEASURE) begin
                count <= '0;
            end else if (state == S_MEASURE) begin
                count <= count_inc;
            end

            // count_inc folds in the edge seen on the final window cycle
            if (state == S_MEASURE && state_nxt == S_REPORT) begin
                result_tap   <= tap;
                result_count <= count_inc;
            end

            clksel       <= (state_nxt == S_IDLE) ? 4'd0 : tap_nxt;
            ring_flush   <= (state_nxt == S_IDLE) || (state_nxt == S_FLUSH);
            busy         <= (state_nxt != S_IDLE);
            result_valid <= (state_nxt == S_REPORT);
            sweep_done   <= (state == S_REPORT) && (state_nxt == S_IDLE) && !abort;
        end
    end

endmodule
